// File: rtl/line_raster_pkg.sv
// line_raster_pkg: shared state type and datapath widths for line raster primitives
package line_raster_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
    localparam int ERR_W = 14;
    localparam int HW = 11;
    localparam int VW = 10;
endpackage

// File: rtl/line_step.sv
// line_step: one combinational Bresenham step on position, framebuffer address and error term
module line_step
    import line_raster_pkg::*;
#(
    parameter int FB_WIDTH = 320,
    parameter int ADDR_W = 16
) (
    input  logic [HW-1:0]           x,
    input  logic [VW-1:0]           y,
    input  logic [ADDR_W-1:0]       addr,
    input  logic signed [ERR_W-1:0] err,
    input  logic signed [11:0]      dx,
    input  logic signed [11:0]      dy,
    input  logic                    sx,
    input  logic                    sy,
    output logic [HW-1:0]           nx,
    output logic [VW-1:0]           ny,
    output logic [ADDR_W-1:0]       naddr,
    output logic signed [ERR_W-1:0] nerr
);
    localparam logic [ADDR_W-1:0] ROW = ADDR_W'(FB_WIDTH);
    logic signed [ERR_W-1:0] e2, dx_e, dy_e;
    logic step_x, step_y;
    assign dx_e = {{(ERR_W-12){dx[11]}}, dx};
    assign dy_e = {{(ERR_W-12){dy[11]}}, dy};
    assign e2 = err <<< 1;
    assign step_x = e2 >= dy_e;
    assign step_y = e2 <= dx_e;
    assign nx = step_x ? (sx ? x - 1'b1 : x + 1'b1) : x;
    assign ny = step_y ? (sy ? y - 1'b1 : y + 1'b1) : y;
    // address wraps modulo 2^ADDR_W off-screen and becomes exact again once back on-screen
    assign naddr = addr + (step_x ? (sx ? '1 : ADDR_W'(1)) : '0) + (step_y ? (sy ? -ROW : ROW) : '0);
    assign nerr = err + (step_x ? dy_e : '0) + (step_y ? dx_e : '0);
endmodule

// File: rtl/line_raster_writer.sv
// line_raster_writer: walks a line segment once and streams one clipped framebuffer write per pixel
module line_raster_writer
    import line_raster_pkg::*;
#(
    parameter int          FB_WIDTH  = 320,
    parameter int          FB_HEIGHT = 180,
    parameter logic [23:0] COLOR     = 24'hFF_FF_FF,
    parameter int          ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [10:0]       x1_in,
    input  logic [9:0]        y1_in,
    input  logic [10:0]       x2_in,
    input  logic [9:0]        y2_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              pix_valid_out,
    input  logic              pix_ready_in,
    output logic [10:0]       pix_x_out,
    output logic [9:0]        pix_y_out,
    output logic [ADDR_W-1:0] pix_addr_out,
    output logic [23:0]       pix_color_out
);
    localparam logic [HW-1:0] W_LIM = HW'(FB_WIDTH);
    localparam logic [VW-1:0] H_LIM = VW'(FB_HEIGHT);
    state_t state;
    logic [HW-1:0] x2_q, nx;
    logic [VW-1:0] y2_q, ny;
    logic signed [11:0] dx, dy, xd, yd;
    logic signed [ERR_W-1:0] err, nerr;
    logic [ADDR_W-1:0] naddr;
    logic sx, sy, consume, last;
    assign pix_color_out = COLOR;
    assign xd = {1'b0, x2_q} - {1'b0, pix_x_out};
    assign yd = {2'b0, y2_q} - {2'b0, pix_y_out};
    assign consume = !pix_valid_out || pix_ready_in;
    assign last = pix_x_out == x2_q && pix_y_out == y2_q;

    line_step #(.FB_WIDTH(FB_WIDTH), .ADDR_W(ADDR_W)) u_step (
        .x(pix_x_out), .y(pix_y_out), .addr(pix_addr_out), .err(err),
        .dx(dx), .dy(dy), .sx(sx), .sy(sy),
        .nx(nx), .ny(ny), .naddr(naddr), .nerr(nerr)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            pix_valid_out <= 1'b0;
            pix_x_out <= '0;
            pix_y_out <= '0;
            pix_addr_out <= '0;
            x2_q <= '0;
            y2_q <= '0;
            dx <= '0;
            dy <= '0;
            err <= '0;
            sx <= 1'b0;
            sy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    pix_x_out <= x1_in;
                    pix_y_out <= y1_in;
                    x2_q <= x2_in;
                    y2_q <= y2_in;
                    busy_out <= 1'b1;
                    state <= SETUP;
                end
                SETUP: begin
                    dx <= xd[11] ? -xd : xd;
                    dy <= yd[11] ? yd : -yd;
                    err <= ERR_W'(xd[11] ? -xd : xd) + ERR_W'(yd[11] ? yd : -yd);
                    sx <= xd[11];
                    sy <= yd[11];
                    pix_addr_out <= ADDR_W'(int'(pix_y_out) * FB_WIDTH + int'(pix_x_out));
                    pix_valid_out <= pix_x_out < W_LIM && pix_y_out < H_LIM;
                    state <= DRAW;
                end
                DRAW: if (consume) begin
                    if (last) begin
                        pix_valid_out <= 1'b0;
                        done_out <= 1'b1;
                        state <= DONE;
                    end else begin
                        pix_x_out <= nx;
                        pix_y_out <= ny;
                        pix_addr_out <= naddr;
                        err <= nerr;
                        pix_valid_out <= nx < W_LIM && ny < H_LIM;
                    end
                end
                default: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_raster_writer.sv
// tb_line_raster_writer: scoreboard bench driving segments and checking pixel stream, timing and reset
module tb_line_raster_writer;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic start_in = 1'b0;
    logic [10:0] x1_in = '0, x2_in = '0;
    logic [9:0] y1_in = '0, y2_in = '0;
    logic busy_out, done_out, pix_valid_out;
    logic pix_ready_in = 1'b1;
    logic [10:0] pix_x_out;
    logic [9:0] pix_y_out;
    logic [15:0] pix_addr_out;
    logic [23:0] pix_color_out;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {int x; int y; int a;} pix_t;
    pix_t sb[$];

    line_raster_writer dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .x1_in(x1_in), .y1_in(y1_in), .x2_in(x2_in), .y2_in(y2_in),
        .busy_out(busy_out), .done_out(done_out), .pix_valid_out(pix_valid_out),
        .pix_ready_in(pix_ready_in), .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
        .pix_addr_out(pix_addr_out), .pix_color_out(pix_color_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int x1, input int y1, input int x2, input int y2, output int n, output int emitted);
        int dx, dy, sx, sy, err, e2, x, y;
        pix_t p;
        dx = x2 > x1 ? x2 - x1 : x1 - x2;
        dy = -(y2 > y1 ? y2 - y1 : y1 - y2);
        sx = x2 >= x1 ? 1 : -1;
        sy = y2 >= y1 ? 1 : -1;
        err = dx + dy;
        x = x1;
        y = y1;
        n = 0;
        emitted = 0;
        while (1) begin
            n++;
            if (x < 320 && y < 180) begin
                p.x = x; p.y = y; p.a = y * 320 + x;
                sb.push_back(p);
                emitted++;
            end
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // mode 0: ready high, 1: three stall cycles on the second pixel, 2: random ready
    task automatic run_line(input int x1, input int y1, input int x2, input int y2, input int mode, input int ign_at);
        int n, emitted, hs, stalls, stall_cnt, held, first, done_rel, t0, rel;
        logic prev_stall;
        logic [31:0] hx, hy, ha;
        pix_t p;
        model(x1, y1, x2, y2, n, emitted);
        @(posedge clk_in); #1;
        x1_in = 11'(x1); y1_in = 10'(y1); x2_in = 11'(x2); y2_in = 10'(y2);
        start_in = 1'b1;
        t0 = cyc;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        x1_in = 11'($urandom); y1_in = 10'($urandom); x2_in = 11'($urandom); y2_in = 10'($urandom);
        hs = 0; stalls = 0; stall_cnt = 0; held = 0; first = -1; done_rel = -1;
        prev_stall = 1'b0; hx = '0; hy = '0; ha = '0;
        for (int c = 0; c < 2000 && done_rel < 0; c++) begin
            rel = cyc - t0;
            if (done_out) done_rel = rel;
            start_in = rel == ign_at;
            if (mode == 1 && hs == 1 && pix_valid_out && stall_cnt < 3) begin
                pix_ready_in = 1'b0;
                stall_cnt++;
            end else
                pix_ready_in = mode == 2 ? $urandom_range(0, 3) != 0 : 1'b1;
            if (prev_stall) begin
                check("hold_valid", pix_valid_out, 1);
                check("hold_x", pix_x_out, hx);
                check("hold_y", pix_y_out, hy);
                check("hold_addr", pix_addr_out, ha);
            end
            if (pix_valid_out && first < 0) first = rel;
            if (pix_valid_out && hs == 1) held++;
            if (pix_valid_out && pix_ready_in) begin
                if (sb.size() == 0) check("unexpected_pixel", pix_x_out, 32'hFFFF_FFFF);
                else begin
                    p = sb.pop_front();
                    check("pix_x", pix_x_out, p.x);
                    check("pix_y", pix_y_out, p.y);
                    check("pix_addr", pix_addr_out, p.a);
                    check("pix_color", pix_color_out, 32'h00FF_FFFF);
                end
                hs++;
            end
            prev_stall = pix_valid_out && !pix_ready_in;
            stalls += int'(prev_stall);
            hx = pix_x_out; hy = pix_y_out; ha = pix_addr_out;
            @(posedge clk_in); #1;
        end
        start_in = 1'b0;
        pix_ready_in = 1'b1;
        check("done_cycle", done_rel, 2 + n + stalls);
        check("pix_count", hs, emitted);
        check("queue_empty", sb.size(), 0);
        if (x1 < 320 && y1 < 180) check("first_valid", first, 2);
        if (mode == 1) check("held_cycles", held, 4);
        check("idle_busy", busy_out, 0);
        check("idle_done", done_out, 0);
        sb.delete();
    endtask

    task automatic reset_mid_line();
        int n, emitted, pulses, valids;
        model(0, 0, 100, 50, n, emitted);
        @(posedge clk_in); #1;
        x1_in = 0; y1_in = 0; x2_in = 100; y2_in = 50;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
        check("mid_busy_before_rst", busy_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("rst_busy", busy_out, 0);
        check("rst_valid", pix_valid_out, 0);
        check("rst_done", done_out, 0);
        check("rst_x", pix_x_out, 0);
        check("rst_y", pix_y_out, 0);
        check("rst_addr", pix_addr_out, 0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        pulses = 0; valids = 0;
        for (int c = 0; c < 20; c++) begin
            pulses += int'(done_out);
            valids += int'(pix_valid_out);
            @(posedge clk_in); #1;
        end
        check("no_done_after_rst", pulses, 0);
        check("no_valid_after_rst", valids, 0);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_busy", busy_out, 0);
        check("reset_done", done_out, 0);
        check("reset_valid", pix_valid_out, 0);
        check("reset_x", pix_x_out, 0);
        check("reset_y", pix_y_out, 0);
        check("reset_addr", pix_addr_out, 0);
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        run_line(10, 5, 14, 5, 0, -1);
        run_line(3, 10, 5, 4, 0, -1);
        run_line(10, 5, 14, 5, 1, -1);
        run_line(7, 7, 7, 7, 0, -1);
        run_line(318, 0, 322, 0, 0, -1);
        run_line(0, 0, 40, 17, 0, 5);
        run_line(319, 179, 0, 0, 0, 10);
        run_line(330, 100, 250, 200, 0, -1);
        for (int i = 0; i < 6; i++)
            run_line($urandom_range(0, 340), $urandom_range(0, 190), $urandom_range(0, 340), $urandom_range(0, 190), 2, -1);
        reset_mid_line();
        run_line(20, 30, 25, 60, 2, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
